// File: rtl/sync_fifo_param_pkg.sv
// Shared constants, depth helper and operation encoding for the single-clock FIFO.
package sync_fifo_pkg;
  localparam int DATASIZE_DEF = 8;
  localparam int ADDRSIZE_DEF = 4;

  function automatic int depth_f(input int addrsize);
    return 1 << addrsize;
  endfunction

  typedef enum logic [1:0] {OP_IDLE, OP_WR, OP_RD, OP_WRRD} fifo_op_e;
endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake bundle for sync_fifo_param; SYNC_FIFO_ERR_FLAGS_EN adds sticky error flags.
interface sync_fifo_param_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
);
  logic                wr_en;
  logic [DATASIZE-1:0] wdata;
  logic                wr_full;
  logic                rd_en;
  logic [DATASIZE-1:0] rdata;
  logic                rempty;
  logic                almost_full;
  logic                almost_empty;
  logic [ADDRSIZE:0]   count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic                err_clr;
  logic                overflow;
  logic                underflow;

  modport master (output wr_en, wdata, rd_en, err_clr,
                  input  wr_full, rdata, rempty, almost_full, almost_empty, count,
                         overflow, underflow);
  modport slave  (input  wr_en, wdata, rd_en, err_clr,
                  output wr_full, rdata, rempty, almost_full, almost_empty, count,
                         overflow, underflow);
`else
  modport master (output wr_en, wdata, rd_en,
                  input  wr_full, rdata, rempty, almost_full, almost_empty, count);
  modport slave  (input  wr_en, wdata, rd_en,
                  output wr_full, rdata, rempty, almost_full, almost_empty, count);
`endif
endinterface

// File: rtl/sync_fifo_param_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, never cleared.
module sync_fifo_mem #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [ADDRSIZE-1:0] i_waddr,
  input  logic [DATASIZE-1:0] i_wdata,
  input  logic [ADDRSIZE-1:0] i_raddr,
  output logic [DATASIZE-1:0] o_rdata
);
  logic [DATASIZE-1:0] r_mem [2**ADDRSIZE];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with fill count, almost flags and registered/FWFT read modes.
// Optional sticky overflow/underflow flags under SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATASIZE      = DATASIZE_DEF,
  parameter int ADDRSIZE      = ADDRSIZE_DEF,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  sync_fifo_param_if.slave bus
);
  localparam int                DEPTH    = depth_f(ADDRSIZE);
  localparam logic [ADDRSIZE:0] C_DEPTH  = (ADDRSIZE+1)'(DEPTH);
  localparam logic [ADDRSIZE:0] C_AFULL  = (ADDRSIZE+1)'(AFULL_THRESH);
  localparam logic [ADDRSIZE:0] C_AEMPTY = (ADDRSIZE+1)'(AEMPTY_THRESH);

  logic [ADDRSIZE:0]   r_wptr;
  logic [ADDRSIZE:0]   r_rptr;
  logic [ADDRSIZE:0]   r_count;
  logic                w_full;
  logic                w_empty;
  logic                w_wr_acc;
  logic                w_rd_acc;
  logic [DATASIZE-1:0] w_mem_rdata;
  fifo_op_e            w_op;

  // Flags come from the registered count only, so no request-to-flag path exists.
  assign w_full   = (r_count == C_DEPTH);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = bus.wr_en & ~w_full;
  assign w_rd_acc = bus.rd_en & ~w_empty;

  always_comb begin
    w_op = OP_IDLE;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_op = OP_WR;
      2'b01:   w_op = OP_RD;
      2'b11:   w_op = OP_WRRD;
      default: w_op = OP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      case (w_op)
        OP_WR:   r_count <= r_count + 1'b1;
        OP_RD:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  sync_fifo_mem #(.DATASIZE(DATASIZE), .ADDRSIZE(ADDRSIZE)) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr[ADDRSIZE-1:0]),
    .i_wdata (bus.wdata),
    .i_raddr (r_rptr[ADDRSIZE-1:0]),
    .o_rdata (w_mem_rdata)
  );

  generate
    if (FWFT == 0) begin : g_reg_rd
      logic [DATASIZE-1:0] r_rdata;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_rdata <= '0;
        else if (w_rd_acc) r_rdata <= w_mem_rdata;
      end
      assign bus.rdata = r_rdata;
    end else begin : g_fwft_rd
      assign bus.rdata = w_mem_rdata;
    end
  endgenerate

  assign bus.wr_full      = w_full;
  assign bus.rempty       = w_empty;
  assign bus.almost_full  = (r_count >= C_AFULL);
  assign bus.almost_empty = (r_count <= C_AEMPTY);
  assign bus.count        = r_count;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.wr_en && w_full)  r_overflow  <= 1'b1;
      else if (bus.err_clr)     r_overflow  <= 1'b0;
      if (bus.rd_en && w_empty) r_underflow <= 1'b1;
      else if (bus.err_clr)     r_underflow <= 1'b0;
    end
  end

  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: registered-read and FWFT instances driven in lockstep
// against a queue model, plus directed literal checks.
module tb_sync_fifo_param;
  localparam int DS    = 8;
  localparam int AS    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic          rd_en;
  logic [DS-1:0] wdata;
  logic          err_clr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DS-1:0] mq[$];
  logic [DS-1:0] m_rdata;
  logic          m_ovf;
  logic          m_unf;

  sync_fifo_param_if #(.DATASIZE(DS), .ADDRSIZE(AS)) if0 ();
  sync_fifo_param_if #(.DATASIZE(DS), .ADDRSIZE(AS)) if1 ();

  assign if0.wr_en = wr_en;
  assign if0.rd_en = rd_en;
  assign if0.wdata = wdata;
  assign if1.wr_en = wr_en;
  assign if1.rd_en = rd_en;
  assign if1.wdata = wdata;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  assign if0.err_clr = err_clr;
  assign if1.err_clr = err_clr;
`endif

  sync_fifo_param #(.DATASIZE(DS), .ADDRSIZE(AS), .AFULL_THRESH(12), .AEMPTY_THRESH(2), .FWFT(0))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  sync_fifo_param #(.DATASIZE(DS), .ADDRSIZE(AS), .AFULL_THRESH(12), .AEMPTY_THRESH(2), .FWFT(1))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a queue of stored words, updated from the request rules at each edge.
  initial begin
    mq.delete();
    m_rdata = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_rdata = '0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
      end else begin
        automatic int  sz = mq.size();
        automatic bit  wa = wr_en && (sz < DEPTH);
        automatic bit  ra = rd_en && (sz > 0);
        if (wr_en && sz == DEPTH) m_ovf = 1'b1;
        else if (err_clr)         m_ovf = 1'b0;
        if (rd_en && sz == 0)     m_unf = 1'b1;
        else if (err_clr)         m_unf = 1'b0;
        if (ra) m_rdata = mq.pop_front();
        if (wa) mq.push_back(wdata);
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        automatic int sz = mq.size();
        chk("count0",   32'(if0.count),        32'(sz));
        chk("count1",   32'(if1.count),        32'(sz));
        chk("full0",    32'(if0.wr_full),      32'(sz == DEPTH));
        chk("empty0",   32'(if0.rempty),       32'(sz == 0));
        chk("empty1",   32'(if1.rempty),       32'(sz == 0));
        chk("afull0",   32'(if0.almost_full),  32'(sz >= 12));
        chk("aempty0",  32'(if0.almost_empty), 32'(sz <= 2));
        chk("rdata0",   32'(if0.rdata),        32'(m_rdata));
        chk("cnt_max",  32'(if0.count <= 5'(DEPTH)), 32'(1));
        if (sz > 0) chk("rdata_fwft", 32'(if1.rdata), 32'(mq[0]));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("ovf0", 32'(if0.overflow),  32'(m_ovf));
        chk("unf0", 32'(if0.underflow), 32'(m_unf));
        chk("ovf1", 32'(if1.overflow),  32'(m_ovf));
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DS-1:0] d);
    wr_en = 1'b1; rd_en = 1'b0; wdata = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0; err_clr = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_count", 32'(if0.count), 32'(0));
    chk("rst_empty", 32'(if0.rempty), 32'(1));
    chk("rst_aempty", 32'(if0.almost_empty), 32'(1));
    chk("rst_full", 32'(if0.wr_full), 32'(0));
    chk("rst_rdata", 32'(if0.rdata), 32'(0));

    // Reset in the middle of a stream
    for (int i = 0; i < 5; i++) wr(8'(8'h10 + i));
    chk("pre_rst_count", 32'(if0.count), 32'(5));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(if0.count), 32'(0));
    chk("async_rst_empty", 32'(if0.rempty), 32'(1));
    chk("async_rst_aempty", 32'(if0.almost_empty), 32'(1));
    chk("async_rst_full", 32'(if0.wr_full), 32'(0));
    step();
    rst_n = 1'b1;
    wr(8'h77);
    chk("post_rst_fwft", 32'(if1.rdata), 32'(8'h77));
    wr(8'h78);
    rd();
    chk("post_rst_first", 32'(if0.rdata), 32'(8'h77));
    rd();
    chk("post_rst_second", 32'(if0.rdata), 32'(8'h78));

    // Fill and drain
    for (int i = 0; i < 16; i++) begin
      wr(8'(i));
      chk("fill_afull", 32'(if0.almost_full), 32'((i + 1) >= 12));
    end
    chk("fill_full", 32'(if0.wr_full), 32'(1));
    chk("model_size16", 32'(mq.size()), 32'(16));
    wr(8'hAA);
    chk("drop_count", 32'(if0.count), 32'(16));
    for (int i = 0; i < 16; i++) begin
      rd();
      chk("drain_rdata", 32'(if0.rdata), 32'(i));
    end
    chk("drain_empty", 32'(if0.rempty), 32'(1));

    // Simultaneous operations at mid, full and empty
    for (int i = 0; i < 8; i++) wr(8'(8'h20 + i));
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; wdata = 8'(8'h30 + i);
      step();
    end
    wr_en = 1'b0; rd_en = 1'b0;
    chk("simul_count", 32'(if0.count), 32'(8));
    chk("simul_last_rd", 32'(if0.rdata), 32'(8'h3B));
    for (int i = 0; i < 8; i++) wr(8'(8'h50 + i));
    wr_en = 1'b1; rd_en = 1'b1; wdata = 8'hEE;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("full_both_count", 32'(if0.count), 32'(15));
    chk("full_both_rdata", 32'(if0.rdata), 32'(8'h3C));
    for (int i = 0; i < 15; i++) rd();
    chk("drain15_rdata", 32'(if0.rdata), 32'(8'h57));
    wr_en = 1'b1; rd_en = 1'b1; wdata = 8'h99;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("empty_both_count", 32'(if0.count), 32'(1));
    chk("empty_both_rdata", 32'(if0.rdata), 32'(8'h57));
    chk("empty_both_fwft", 32'(if1.rdata), 32'(8'h99));
    rd();

    // FWFT head visibility
    wr(8'h5A);
    chk("fwft_nonempty", 32'(if1.rempty), 32'(0));
    chk("fwft_head", 32'(if1.rdata), 32'(8'h5A));
    rd();
    chk("fwft_pop_empty", 32'(if1.rempty), 32'(1));

    // Pointer wrap with random data
    for (int i = 0; i < 40; i++) begin
      wr(8'($urandom_range(0, 255)));
      if (i % 3 == 0) wr(8'($urandom_range(0, 255)));
      rd();
      if (i % 3 == 2) rd();
    end
    while (mq.size() > 0 && n_tests < 100000) rd();
    chk("wrap_end_count", 32'(if0.count), 32'(0));

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    rd();
    chk("unf_set", 32'(if0.underflow), 32'(1));
    step();
    chk("unf_sticky", 32'(if0.underflow), 32'(1));
    for (int i = 0; i < 16; i++) wr(8'(i));
    chk("ovf_before", 32'(if0.overflow), 32'(0));
    wr(8'hC3);
    chk("ovf_set", 32'(if0.overflow), 32'(1));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_ovf", 32'(if0.overflow), 32'(0));
    chk("clr_unf", 32'(if0.underflow), 32'(0));
    err_clr = 1'b1; wr_en = 1'b1; wdata = 8'h11;
    step();
    err_clr = 1'b0; wr_en = 1'b0;
    chk("set_wins_ovf", 32'(if0.overflow), 32'(1));
    chk("set_wins_unf", 32'(if0.underflow), 32'(0));
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
